// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the instruction-ROM port, the redirect input and the
// downstream instruction handshake of the fetch stage.
//   master : the fetch unit (drives imem_req/imem_addr and inst_*)
//   slave  : the environment (ROM, branch resolution, decode)
//   imem_req/imem_addr/imem_rdata  : 1-cycle-latency synchronous ROM port
//   redirect_valid/redirect_pc     : taken branch/jump target, single-cycle pulse
//   inst_valid/inst_data/inst_pc   : FIFO head presented downstream
//   inst_ready                     : downstream accepts the head this cycle
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues sequential word-aligned PCs to a
// 1-cycle-latency ROM, buffers returned words with their PCs in a DEPTH-entry
// FIFO and presents the head downstream via valid/ready. A redirect flushes the
// FIFO and the outstanding response and restarts fetch at the new target.
//   clk     : core clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fetch_unit_if.master (ROM port, redirect, instruction handshake)
// Parameters: RESET_PC (first fetch address), DEPTH (FIFO entries, power of 2, >= 2)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_unit_if.master  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];

  logic          pop;
  logic          push;
  logic          req;
  logic [CW:0]   occ;

  // Low target bits are architecturally ignored.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_comb begin
    pop  = (count_q != '0) & bus.inst_ready;
    push = inflight_q & ~kill_q & ~bus.redirect_valid;
    // Occupancy the FIFO will have once the outstanding response lands, net of
    // this cycle's pop; a new request is only issued if it is guaranteed a slot.
    occ  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    req  = reset_n & ~bus.redirect_valid & (occ < (CW+1)'(DEPTH));

    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (bus.redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      kill_d     = 1'b0;
      inflight_d = 1'b0;
    end else begin
      if (req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pc_d       = fetch_pc_q;
      end
      inflight_d = req;
      // kill only drops one due response; redirect already suppresses the
      // request in its own cycle, so nothing outstanding survives a redirect.
      if (inflight_q && kill_q) kill_d = 1'b0;
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else if (push) begin
      mem_pc_q[tail_q]   <= pc_q;
      mem_data_q[tail_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_data  = mem_data_q[head_q];
  assign bus.inst_pc    = mem_pc_q[head_q];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Stimulus pushes the expected
// {pc, data} stream into a queue; a negedge monitor pops and compares on every
// accepted instruction. Directed cycle checks cover reset, latency, backpressure,
// redirects (including misaligned target and address wrap) and mid-run reset.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t exp_q[$];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0020_0293;
      32'h0000_0004: return 32'h0000_0013;
      default:       return 32'h5A5A_0000 ^ addr;
    endcase
  endfunction

  // ROM: 1-cycle-latency synchronous read.
  always @(posedge clk)
    if (bus.imem_req) bus.imem_rdata <= rom_word(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = rom_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_pop: got pc %h expected none", bus.inst_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_pc", bus.inst_pc, e.pc);
        chk("pop_data", bus.inst_data, e.data);
      end
    end
  end

  initial begin
    reset_n            = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_data", bus.inst_data, 32'h0);
    chk("rst_pc", bus.inst_pc, 32'h0);

    // Reset release with inst_ready high: 0, 4, 8 from cycle 2.
    nxt(); reset_n = 1'b1; bus.inst_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    @(negedge clk);
    chk("c0_req", 32'(bus.imem_req), 32'd1);
    chk("c0_addr", bus.imem_addr, 32'h0);
    chk("c0_valid", 32'(bus.inst_valid), 32'd0);
    nxt(); @(negedge clk);
    chk("c1_valid", 32'(bus.inst_valid), 32'd0);
    chk("c1_addr", bus.imem_addr, 32'h4);
    nxt(); @(negedge clk);
    chk("c2_valid", 32'(bus.inst_valid), 32'd1);
    chk("c2_pc", bus.inst_pc, 32'h0);
    nxt(); nxt();

    // beq taken to 0x0 with 0xC buffered and 0x10 in flight.
    nxt();
    chk("A_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    @(negedge clk);
    chk("rdA_req", 32'(bus.imem_req), 32'd0);
    nxt(); bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("rdA1_req", 32'(bus.imem_req), 32'd1);
    chk("rdA1_addr", bus.imem_addr, 32'h0);
    chk("rdA1_valid", 32'(bus.inst_valid), 32'd0);
    nxt(); @(negedge clk);
    chk("rdA2_valid", 32'(bus.inst_valid), 32'd0);
    chk("rdA2_addr", bus.imem_addr, 32'h4);

    // Backpressure: head held at 0x0 for 6 cycles, requests stopped.
    for (int i = 0; i < 6; i++) begin
      nxt(); @(negedge clk);
      chk("bp_valid", 32'(bus.inst_valid), 32'd1);
      chk("bp_pc", bus.inst_pc, 32'h0);
      chk("bp_data", bus.inst_data, 32'h0020_0293);
      chk("bp_req", 32'(bus.imem_req), 32'd0);
    end
    nxt(); bus.inst_ready = 1'b1;
    nxt(); nxt();

    // Redirect to misaligned 0x13 -> fetch from 0x10.
    nxt();
    chk("B_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h13;
    expect_pc(32'h10); expect_pc(32'h14);
    @(negedge clk);
    chk("rdB_req", 32'(bus.imem_req), 32'd0);
    nxt(); bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("rdB1_req", 32'(bus.imem_req), 32'd1);
    chk("rdB1_addr", bus.imem_addr, 32'h10);
    chk("rdB1_valid", 32'(bus.inst_valid), 32'd0);
    nxt(); @(negedge clk);
    chk("rdB2_valid", 32'(bus.inst_valid), 32'd0);
    nxt(); @(negedge clk);
    chk("rdB3_valid", 32'(bus.inst_valid), 32'd1);
    chk("rdB3_pc", bus.inst_pc, 32'h10);
    nxt();

    // Redirect to 0xFFFF_FFFC: sequence wraps to 0x0.
    nxt();
    chk("C_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    expect_pc(32'hFFFF_FFFC); expect_pc(32'h0); expect_pc(32'h4);
    nxt(); bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("rdC1_addr", bus.imem_addr, 32'hFFFF_FFFC);
    nxt(); @(negedge clk);
    chk("rdC2_req", 32'(bus.imem_req), 32'd1);
    chk("rdC2_addr", bus.imem_addr, 32'h0);
    nxt(); nxt(); nxt();

    // Fill the FIFO, then reset for one cycle.
    nxt(); bus.inst_ready = 1'b0;
    chk("D_drained", 32'(exp_q.size()), 32'd0);
    nxt(); nxt(); @(negedge clk);
    chk("full_valid", 32'(bus.inst_valid), 32'd1);
    chk("full_req", 32'(bus.imem_req), 32'd0);
    nxt(); reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.inst_valid), 32'd0);
    chk("arst_pc", bus.inst_pc, 32'h0);
    chk("arst_data", bus.inst_data, 32'h0);
    chk("arst_req", 32'(bus.imem_req), 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    exp_q.delete();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    nxt(); reset_n = 1'b1; bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("r0_req", 32'(bus.imem_req), 32'd1);
    chk("r0_addr", bus.imem_addr, 32'h0);
    chk("r0_valid", 32'(bus.inst_valid), 32'd0);
    nxt(); @(negedge clk);
    chk("r1_valid", 32'(bus.inst_valid), 32'd0);
    nxt(); @(negedge clk);
    chk("r2_valid", 32'(bus.inst_valid), 32'd1);
    chk("r2_pc", bus.inst_pc, 32'h0);
    nxt(); nxt();
    nxt(); bus.inst_ready = 1'b0;
    chk("E_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
